// File: rtl/mux_arbitrado_n_pkg.sv
// Shared definitions for the N-channel arbitrated output mux.
package mux_arbitrado_n_pkg;
  localparam logic MODO_FIXO = 1'b0;
  localparam logic MODO_RR   = 1'b1;
endpackage

// File: rtl/mux_arbitrado_n_arbitro_rr.sv
// Combinational round-robin arbiter: first requester after ptr, ptr itself last.
module arbitro_rr #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] idx,
  output logic            any
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = SELW'(j);
      end
    end
  end

endmodule

// File: rtl/mux_arbitrado_n.sv
// N-channel valid/ready mux into one registered output; fixed or round-robin select.
module mux_arbitrado_n
  import mux_arbitrado_n_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               modo,
  input  logic [SELW-1:0]    sel_fixo,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [N-1:0]     rr_grant;
  logic [SELW-1:0]  rr_idx;
  logic             rr_any;

  logic             fix_vld, cand_vld, can_load, take;
  logic [SELW-1:0]  cand_idx;
  logic [WIDTH-1:0] cand_data;
  logic [N-1:0]     fix_onehot;

  arbitro_rr #(.N(N), .SELW(SELW)) u_arbitro_rr (
    .req   (in_valid),
    .ptr   (ptr_q),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  always_comb begin
    fix_vld    = 1'b0;
    fix_onehot = '0;
    cand_data  = '0;
    // Out-of-range sel_fixo matches no channel, so it can never grant.
    for (int i = 0; i < N; i++) begin
      if (sel_fixo == SELW'(i)) begin
        fix_vld       = in_valid[i];
        fix_onehot[i] = 1'b1;
      end
    end

    if (modo == MODO_RR) begin
      cand_vld = rr_any;
      cand_idx = rr_idx;
    end else begin
      cand_vld = fix_vld;
      cand_idx = sel_fixo;
    end

    for (int i = 0; i < N; i++) begin
      if (cand_idx == SELW'(i)) cand_data = in_data[i*WIDTH +: WIDTH];
    end

    can_load = !out_valid_q || out_ready;
    take     = cand_vld && can_load && !reset;

    if (!take)                in_ready = '0;
    else if (modo == MODO_RR) in_ready = rr_grant;
    else                      in_ready = fix_onehot;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = cand_data;
      out_sel_d   = cand_idx;
      if (modo == MODO_RR) ptr_d = cand_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= SELW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_arbitrado_n.sv
// Scoreboard bench for mux_arbitrado_n (N=4 main instance, N=3 edge-case instance).
module tb_mux_arbitrado_n;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       modo = 1'b1;
  logic       out_ready = 1'b1;
  logic [1:0] sel_fixo = 2'd0;
  logic [3:0] in_valid = 4'b1111;
  logic [7:0] in_data = 8'b00_10_01_11;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [1:0] out_data, out_sel;

  logic       r3_reset = 1'b1;
  logic       r3_modo = 1'b0;
  logic       r3_out_ready = 1'b1;
  logic [1:0] r3_sel = 2'd0;
  logic [2:0] r3_in_valid = 3'b111;
  logic [5:0] r3_in_data = 6'b11_10_01;
  logic [2:0] r3_in_ready;
  logic       r3_out_valid;
  logic [1:0] r3_out_data, r3_out_sel;

  int         checks = 0;
  int         failures = 0;
  bit         done3 = 1'b0;
  logic [3:0] sb_q[$];
  logic [3:0] mon_e;
  logic [1:0] exp_data [4] = '{2'b11, 2'b01, 2'b10, 2'b00};

  always #5 clock = ~clock;

  mux_arbitrado_n #(.WIDTH(2), .N(4)) dut (
    .clock(clock), .reset(reset), .modo(modo), .sel_fixo(sel_fixo),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  mux_arbitrado_n #(.WIDTH(2), .N(3)) dut3 (
    .clock(clock), .reset(r3_reset), .modo(r3_modo), .sel_fixo(r3_sel),
    .in_valid(r3_in_valid), .in_data(r3_in_data), .in_ready(r3_in_ready),
    .out_valid(r3_out_valid), .out_data(r3_out_data), .out_sel(r3_out_sel),
    .out_ready(r3_out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic grant(input int ch);
    sb_q.push_back({exp_data[ch], 2'(ch)});
  endtask

  always @(negedge clock) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_unexpected: got sel=%0d data=%0h expected no word", out_sel, out_data);
      end else begin
        mon_e = sb_q.pop_front();
        chk("mon_data", 32'(out_data), 32'(mon_e[3:2]));
        chk("mon_sel", 32'(out_sel), 32'(mon_e[1:0]));
      end
    end
  end

  initial begin
    int rr_exp [6];
    int sp_exp [5];
    rr_exp = '{0, 1, 2, 3, 0, 1};
    sp_exp = '{0, 3, 0, 3, 0};

    // reset with every channel requesting
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_sel", 32'(out_sel), 32'h0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_ready2", 32'(in_ready), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // round-robin fairness, no gaps
    for (int k = 0; k < 6; k++) begin
      grant(rr_exp[k]);
      @(negedge clock);
      chk("rr_ready", 32'(in_ready), 32'(1 << rr_exp[k]));
      if (k > 0) chk("rr_nogap", 32'(out_valid), 32'h1);
      @(posedge clock); #1;
    end

    // fixed select of channel 2
    modo = 1'b0;
    sel_fixo = 2'd2;
    for (int k = 0; k < 3; k++) begin
      grant(2);
      @(negedge clock);
      chk("fix_ready", 32'(in_ready), 32'h4);
      chk("fix_valid", 32'(out_valid), 32'h1);
      @(posedge clock); #1;
    end

    // backpressure; selection inputs change but the held word must not
    out_ready = 1'b0;
    modo = 1'b1;
    in_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("bp_ready", 32'(in_ready), 32'h0);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_data", 32'(out_data), 32'h2);
      chk("bp_sel", 32'(out_sel), 32'h2);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    grant(3);
    @(negedge clock);
    chk("rel_ready", 32'(in_ready), 32'h8);
    @(posedge clock); #1;
    in_valid = 4'b0000;
    @(negedge clock);
    chk("drain_ready", 32'(in_ready), 32'h0);
    chk("drain_valid", 32'(out_valid), 32'h1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("drained", 32'(out_valid), 32'h0);
    @(posedge clock); #1;

    // sparse round-robin with wrap, from reset
    reset = 1'b1;
    in_valid = 4'b1001;
    modo = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      grant(sp_exp[k]);
      @(negedge clock);
      chk("sp_ready", 32'(in_ready), 32'(1 << sp_exp[k]));
      @(posedge clock); #1;
    end

    // reset mid-stream: pointer must return so channel 0 wins next
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_ready", 32'(in_ready), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    in_valid = 4'b1111;
    grant(0);
    @(negedge clock);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_ready_post", 32'(in_ready), 32'h1);
    @(posedge clock); #1;
    in_valid = 4'b0000;

    for (int t = 0; t < 50 && (sb_q.size() != 0 || !done3); t++) @(posedge clock);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    chk("n3_done", 32'(done3), 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // N=3 instance: out-of-range fixed select and mid-stream reset
  initial begin
    @(posedge clock); #1;
    @(negedge clock);
    chk("n3_rst_ready", 32'(r3_in_ready), 32'h0);
    @(posedge clock); #1;
    r3_reset = 1'b0;
    r3_modo = 1'b0;
    r3_sel = 2'd1;
    @(negedge clock);
    chk("n3_fix_ready", 32'(r3_in_ready), 32'h2);
    @(posedge clock); #1;
    r3_sel = 2'd3;
    @(negedge clock);
    chk("n3_oor_ready", 32'(r3_in_ready), 32'h0);
    chk("n3_held_valid", 32'(r3_out_valid), 32'h1);
    chk("n3_held_data", 32'(r3_out_data), 32'h2);
    chk("n3_held_sel", 32'(r3_out_sel), 32'h1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("n3_oor_ready2", 32'(r3_in_ready), 32'h0);
    chk("n3_drained", 32'(r3_out_valid), 32'h0);
    chk("n3_hold_data", 32'(r3_out_data), 32'h2);
    @(posedge clock); #1;
    r3_modo = 1'b1;
    @(negedge clock);
    chk("n3_rr0", 32'(r3_in_ready), 32'h1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("n3_rr1", 32'(r3_in_ready), 32'h2);
    @(posedge clock); #1;
    r3_reset = 1'b1;
    @(negedge clock);
    chk("n3_mid_rst_ready", 32'(r3_in_ready), 32'h0);
    @(posedge clock); #1;
    r3_reset = 1'b0;
    @(negedge clock);
    chk("n3_after_rst_valid", 32'(r3_out_valid), 32'h0);
    chk("n3_after_rst_ready", 32'(r3_in_ready), 32'h1);
    done3 = 1'b1;
  end

endmodule
